stream_mux_reg: RTL
===================

Name: stream_mux_reg

Overview:
- Parametrised N-to-1 selector for 12-bit datapath buses with a registered output stage and valid/ready handshaking on every port.
- Successor to the combinational 2/3/4-input mux utilities. Adds configurable width and channel count, explicit-select or round-robin arbitration, and back-pressure.
- Sits between multiple producers (ALU result, memory read, immediate, PC path) and a single consumer register, where sources are not always ready in the same cycle.

Parameters:
- WIDTH, 12, data width of each channel and of the output.
- N_IN, 4, number of input channels (2..16).
- MODE, 0, 0 = explicit select via sel port, 1 = round-robin arbitration (sel ignored).
- SEL_W, $clog2(N_IN) (minimum 1), width of sel and out_src.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  channel i offers a word.
- in_ready  output  N_IN  channel i word accepted this cycle when in_valid[i] & in_ready[i].
- sel  input  SEL_W  channel index in MODE 0.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_src  output  SEL_W  index of the channel out_data came from.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_src=0, round-robin pointer=0. in_ready is all-zero while rst_n=0. Reset mid-transfer discards the held word; no partial state survives.
- can_load = ~out_valid | out_ready. A single register stage supports full throughput of 1 word/cycle.
- Grant, MODE 0:
  - grant = onehot(sel) when sel < N_IN, else all-zero.
  - An out-of-range sel never accepts anything, and out_valid falls once the held word drains.
- Grant, MODE 1:
  - Scan in_valid starting at the pointer, wrapping modulo N_IN. Grant the first valid channel.
  - No valid channel gives grant all-zero.
- in_ready[i] = grant[i] & can_load. This is combinational from in_valid/sel/out_valid/out_ready. in_ready never depends on the in_valid of its own channel in MODE 0.
- Transfer: if any grant[i] & in_valid[i] & can_load at the rising edge:
  - out_data <= channel i word; out_src <= i; out_valid <= 1.
  - MODE 1 also sets pointer <= (i+1) mod N_IN.
- If there is no transfer and out_ready=1, out_valid <= 0. out_data and out_src hold their last value.
- Stall: while out_valid=1 & out_ready=0, out_data/out_src are stable and all in_ready=0.
- Latency: an accepted word appears on out_data exactly 1 cycle after its handshake edge.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, and out_valid stays 1 with no bubble.
- The pointer advances only on a transfer, never on idle cycles. A pointer wrap from N_IN-1 goes to 0.
- MODE 0, sel change while stalled: takes effect at the next load. It does not alter the held word.
- No combinational path from in_data to out_data.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=4'b0000 immediately, without waiting for a clock edge.
- MODE 0 streaming: sel=2, in_valid=4'b0100, in_data ch2=12'hA5C, out_ready=1 -> in_ready=4'b0100; next cycle out_data=12'hA5C, out_src=2, out_valid=1. Back-to-back words appear on consecutive cycles.
- Back-pressure: out_ready=0 for 3 cycles holding 12'h123 -> out_data stays 12'h123 and in_ready=0 throughout. When out_ready=1 with ch2 valid 12'h456, the next cycle shows 12'h456 with no bubble.
- Out-of-range sel: N_IN=3, sel=3, all valid -> in_ready=0. out_valid drops after the held word drains.
- MODE 1 fairness: N_IN=4, in_valid=4'b1111 constant, out_ready=1 -> out_src sequence 0,1,2,3,0. in_valid=4'b1001 with pointer=1 -> grants 3 then 0.
- MODE 1 idle: in_valid=0 for 5 cycles after granting ch1 -> pointer stays 2. Next request in_valid=4'b0110 grants ch2 first.

Source files
------------

// File: rtl/stream_mux_reg.sv
// N-to-1 stream selector with one registered output stage and valid/ready on every port.
// Channel choice is either the sel port (MODE 0) or a round-robin scan from a pointer (MODE 1).
module stream_mux_reg #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned MODE  = 0,
    parameter int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic [N_IN-1:0]    grant;
    logic [SEL_W-1:0]   gnt_idx;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_nxt;
    logic [2*N_IN-1:0]  rot_valid;
    logic [WIDTH-1:0]   word;
    logic               found;
    logic               can_load;
    logic               xfer;
    int unsigned        idx;
    int unsigned        idx_inc;

    assign can_load = ~out_valid | out_ready;
    assign xfer     = can_load & (|(grant & in_valid));
    // Forced low during reset so no producer sees a handshake while the stage is cleared
    assign in_ready = rst_n ? (grant & {N_IN{can_load}}) : '0;

    // Grant selection: explicit sel, or first valid channel at/after the pointer
    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        idx       = 0;
        rot_valid = {in_valid, in_valid} >> ptr;
        if (MODE == 0) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (sel == SEL_W'(i)) begin
                    grant[i] = 1'b1;
                    gnt_idx  = sel;
                end
            end
        end else begin
            for (int unsigned j = 0; j < N_IN; j++) begin
                if (!found && rot_valid[j]) begin
                    found = 1'b1;
                    idx   = 32'(ptr) + j;
                    if (idx >= N_IN) begin
                        idx = idx - N_IN;
                    end
                end
            end
            for (int unsigned i = 0; i < N_IN; i++) begin
                grant[i] = found && (idx == i);
            end
            gnt_idx = SEL_W'(idx);
        end
    end

    // Selected word and the pointer value that follows a grant
    always_comb begin
        word    = '0;
        idx_inc = 32'(gnt_idx) + 1;
        ptr_nxt = (idx_inc >= N_IN) ? '0 : SEL_W'(idx_inc);
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_src   <= gnt_idx;
            if (MODE == 1) begin
                ptr <= ptr_nxt;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
